// File: rtl/axi4_burst_ram_slave.sv
// AXI4 slave backed by a 32-bit word RAM, supporting FIXED and INCR bursts
// with independent read and write channels and zero-bubble read streaming.
module axi4_burst_ram_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int DEPTH = 1 << WA_W;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0] mem [DEPTH];

    logic            unused_addr_lsbs;
    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    logic [1:0]      w_state, w_state_nxt;
    logic [WA_W-1:0] w_addr;
    logic [7:0]      w_len, w_cnt;
    logic [1:0]      w_burst;
    logic            w_err;
    logic            aw_hs, w_hs, b_hs;
    logic            w_unsup, w_last_beat, wlast_bad;

    assign aw_hs       = awvalid & awready;
    assign w_hs        = wvalid & wready;
    assign b_hs        = bvalid & bready;
    assign w_unsup     = w_burst[1];
    assign w_last_beat = (w_cnt == w_len);
    assign wlast_bad   = (wlast != w_last_beat);

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they stay
    // glitch-free and drop to zero together with the state on reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            bid     <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            awready <= (w_state_nxt == W_IDLE);
            wready  <= (w_state_nxt == W_DATA);
            bvalid  <= (w_state_nxt == W_RESP);
            if (aw_hs) begin
                bid   <= awid;
                w_err <= 1'b0;
            end
            if (w_hs) begin
                if (wlast_bad) w_err <= 1'b1;
                if (w_last_beat)
                    bresp <= (w_unsup || w_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            w_addr  <= awaddr[ADDR_W-1:2];
            w_len   <= awlen;
            w_burst <= awburst;
            w_cnt   <= 8'd0;
        end else if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_burst == BURST_INCR) w_addr <= w_addr + WA_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_unsup) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    logic [0:0]      r_state, r_state_nxt;
    logic [WA_W-1:0] r_addr;
    logic [7:0]      r_len, r_cnt;
    logic [1:0]      r_burst;
    logic            ar_hs, r_hs, r_unsup;

    assign ar_hs   = arvalid & arready;
    assign r_hs    = rvalid & rready;
    assign r_unsup = r_burst[1];

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && rlast) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // rdata is prefetched: r_addr always points at the word for the beat
    // after the one currently presented, so each handshake reloads at once.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RESP_OKAY;
            rid     <= '0;
            rdata   <= '0;
        end else begin
            r_state <= r_state_nxt;
            arready <= (r_state_nxt == R_IDLE);
            rvalid  <= (r_state_nxt == R_DATA);
            if (ar_hs) begin
                rid   <= arid;
                rresp <= arburst[1] ? RESP_SLVERR : RESP_OKAY;
                rlast <= (arlen == 8'd0);
                rdata <= arburst[1] ? 32'd0 : mem[araddr[ADDR_W-1:2]];
            end else if (r_hs && !rlast) begin
                rlast <= ((r_cnt + 8'd1) == r_len);
                rdata <= r_unsup ? 32'd0 : mem[r_addr];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            r_len   <= arlen;
            r_burst <= arburst;
            r_cnt   <= 8'd0;
            r_addr  <= (arburst == BURST_INCR) ? araddr[ADDR_W-1:2] + WA_W'(1)
                                               : araddr[ADDR_W-1:2];
        end else if (r_hs && !rlast) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_burst == BURST_INCR) r_addr <= r_addr + WA_W'(1);
        end
    end

endmodule
